// File: rtl/sa_result_streamer.sv
// Result matrix capture buffer for the systolic array.
// Drains one matrix row-major over a valid/ready stream.
module sa_result_streamer #(
  parameter int SIZE    = 4,
  parameter int Y_WIDTH = 32,
  parameter int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_matrix_vld,
  input  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] i_matrix,
  output logic                                  o_cap_rdy,
  output logic                                  o_data_vld,
  output logic [Y_WIDTH-1:0]                    o_data,
  output logic [IDX_W-1:0]                      o_row,
  output logic [IDX_W-1:0]                      o_col,
  output logic                                  o_last,
  input  logic                                  i_data_rdy,
  output logic                                  o_ovf,
  input  logic                                  i_ovf_clr
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SIZE - 1);

  state_t state;
  state_t state_nxt;

  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] mat_q;
  logic [Y_WIDTH-1:0] sel;
  logic beat;
  logic cap;
  logic drop;
  logic col_end;
  logic row_end;

  assign col_end    = (o_col == IDX_MAX);
  assign row_end    = (o_row == IDX_MAX);
  assign o_data_vld = (state == SEND);
  assign o_last     = o_data_vld & row_end & col_end;
  assign beat       = o_data_vld & i_data_rdy;
  assign o_cap_rdy  = (state == IDLE) | (beat & o_last);
  assign cap        = i_matrix_vld & o_cap_rdy;
  assign drop       = i_matrix_vld & ~o_cap_rdy;
  assign o_data     = o_data_vld ? sel : '0;

  // Element mux: pick buf[row][col] without a sized array index.
  always_comb begin
    sel = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (o_row == IDX_W'(r) && o_col == IDX_W'(c)) begin
          sel = mat_q[r][c];
        end
      end
    end
  end

  // Matrix buffer; contents are don't-care until first capture.
  always_ff @(posedge clk) begin
    if (cap) begin
      mat_q <= i_matrix;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a capture always lands in SEND, even on the last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cap) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (beat & o_last & ~cap) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Row/col walk: row-major, restarting on every capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_row <= '0;
      o_col <= '0;
    end else if (cap) begin
      o_row <= '0;
      o_col <= '0;
    end else if (beat) begin
      if (col_end) begin
        o_col <= '0;
        o_row <= row_end ? '0 : o_row + 1'b1;
      end else begin
        o_col <= o_col + 1'b1;
      end
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf <= 1'b0;
    end else if (drop) begin
      o_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_result_streamer.sv
// Directed bench for sa_result_streamer.
// Covers a SIZE=4 instance and a SIZE=1 instance.
module tb_sa_result_streamer;

  typedef logic [3:0][3:0][31:0] mat_t;
  typedef logic [0:0][0:0][31:0] mat1_t;

  logic        clk = 0;
  logic        rst_n = 0;

  logic        i_matrix_vld = 0;
  mat_t        i_matrix = '0;
  logic        o_cap_rdy;
  logic        o_data_vld;
  logic [31:0] o_data;
  logic [1:0]  o_row;
  logic [1:0]  o_col;
  logic        o_last;
  logic        i_data_rdy = 0;
  logic        o_ovf;
  logic        i_ovf_clr = 0;

  logic        s_vld = 0;
  mat1_t       s_m = '0;
  logic        s_cap;
  logic        s_dv;
  logic [31:0] s_d;
  logic [0:0]  s_r;
  logic [0:0]  s_c;
  logic        s_l;
  logic        s_rdy = 0;
  logic        s_ovf;
  logic        s_clr = 0;

  int checks = 0;
  int failures = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  sa_result_streamer #(.SIZE(4), .Y_WIDTH(32)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_matrix_vld (i_matrix_vld),
    .i_matrix     (i_matrix),
    .o_cap_rdy    (o_cap_rdy),
    .o_data_vld   (o_data_vld),
    .o_data       (o_data),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_last       (o_last),
    .i_data_rdy   (i_data_rdy),
    .o_ovf        (o_ovf),
    .i_ovf_clr    (i_ovf_clr)
  );

  sa_result_streamer #(.SIZE(1), .Y_WIDTH(32)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_matrix_vld (s_vld),
    .i_matrix     (s_m),
    .o_cap_rdy    (s_cap),
    .o_data_vld   (s_dv),
    .o_data       (s_d),
    .o_row        (s_r),
    .o_col        (s_c),
    .o_last       (s_l),
    .i_data_rdy   (s_rdy),
    .o_ovf        (s_ovf),
    .i_ovf_clr    (s_clr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic mat_t mk_inc();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = 32'(16 * i + j);
    return m;
  endfunction

  function automatic mat_t mk_const(input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = v;
    return m;
  endfunction

  task automatic push_inc();
    for (int k = 0; k < 16; k++)
      expq.push_back(32'(16 * (k / 4) + (k % 4)));
  endtask

  task automatic push_const(input logic [31:0] v);
    for (int k = 0; k < 16; k++)
      expq.push_back(v);
  endtask

  task automatic idle_tick();
    @(negedge clk);
    i_matrix_vld = 0;
    i_data_rdy = 1;
    i_ovf_clr = 0;
    #1;
  endtask

  task automatic capture(input mat_t m);
    @(negedge clk);
    i_matrix = m;
    i_matrix_vld = 1;
    i_data_rdy = 1;
    #1;
    chk("cap_idle_rdy", o_cap_rdy, 1);
    chk("cap_idle_vld", o_data_vld, 0);
  endtask

  task automatic stream(input int n, input bit rnd,
                        input int inj_at, input mat_t inj_m);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    bit done = 0;
    bit drop_prev = 0;
    logic [31:0] pd = 0;
    logic [1:0] pr = 0;
    logic [1:0] pc = 0;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      i_data_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_matrix_vld = 0;
      if (!done && idx == inj_at && i_data_rdy) begin
        i_matrix_vld = 1;
        i_matrix = inj_m;
        done = 1;
      end
      #1;
      if (drop_prev) chk("ovf_set", o_ovf, 1);
      drop_prev = i_matrix_vld && (idx % 16 != 15);
      chk("vld", o_data_vld, 1);
      chk("data", o_data, expq[idx]);
      chk("row", o_row, (idx % 16) / 4);
      chk("col", o_col, idx % 4);
      chk("last", o_last, (idx % 16) == 15);
      chk("cap_rdy", o_cap_rdy,
          i_data_rdy && (idx % 16) == 15);
      if (stalled) begin
        chk("hold_data", o_data, pd);
        chk("hold_row", o_row, pr);
        chk("hold_col", o_col, pc);
      end
      stalled = !i_data_rdy;
      pd = o_data;
      pr = o_row;
      pc = o_col;
      if (i_data_rdy) idx++;
    end
    if (idx < n) chk("timeout", idx, n);
  endtask

  initial begin
    mat_t ma;
    mat_t mb;
    ma = mk_const(32'hA);
    mb = mk_const(32'hB);

    // reset state
    #2;
    chk("rst_vld", o_data_vld, 0);
    chk("rst_data", o_data, 0);
    chk("rst_row", o_row, 0);
    chk("rst_col", o_col, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_cap", o_cap_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle_tick();
    chk("idle_vld", o_data_vld, 0);

    // basic drain
    expq = {};
    push_inc();
    capture(mk_inc());
    stream(16, 0, -1, ma);
    idle_tick();
    chk("drain_end_vld", o_data_vld, 0);
    chk("drain_end_last", o_last, 0);

    // backpressure
    expq = {};
    push_inc();
    capture(mk_inc());
    stream(16, 1, -1, ma);
    idle_tick();
    chk("bp_end_vld", o_data_vld, 0);

    // back-to-back, B aligned to A's last beat
    expq = {};
    push_const(32'hA);
    push_const(32'hB);
    capture(ma);
    stream(32, 0, 15, mb);
    idle_tick();
    chk("b2b_end_vld", o_data_vld, 0);
    chk("b2b_ovf", o_ovf, 0);

    // overflow: second matrix offered at beat 5 is dropped
    expq = {};
    push_inc();
    capture(mk_inc());
    stream(16, 0, 5, mb);
    idle_tick();
    chk("ovf_end_vld", o_data_vld, 0);
    chk("ovf_sticky", o_ovf, 1);

    // clear alone
    @(negedge clk);
    i_ovf_clr = 1;
    idle_tick();
    chk("ovf_clr", o_ovf, 0);

    // clear with simultaneous drop: set wins
    expq = {};
    push_inc();
    capture(mk_inc());
    @(negedge clk);
    i_matrix_vld = 1;
    i_matrix = mb;
    i_ovf_clr = 1;
    i_data_rdy = 0;
    #1;
    chk("drop_cap_rdy", o_cap_rdy, 0);
    @(negedge clk);
    i_matrix_vld = 0;
    i_ovf_clr = 0;
    #1;
    chk("ovf_set_wins", o_ovf, 1);
    stream(16, 0, -1, ma);
    idle_tick();
    chk("sw_end_vld", o_data_vld, 0);

    // reset mid-stream (o_ovf still 1 here)
    expq = {};
    push_inc();
    capture(mk_inc());
    stream(8, 0, -1, ma);
    @(negedge clk);
    i_data_rdy = 0;
    #1;
    chk("pre_rst_ovf", o_ovf, 1);
    chk("pre_rst_row", o_row, 2);
    rst_n = 0;
    #1;
    chk("mid_rst_vld", o_data_vld, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_ovf", o_ovf, 0);
    chk("mid_rst_row", o_row, 0);
    chk("mid_rst_col", o_col, 0);
    @(negedge clk);
    rst_n = 1;
    idle_tick();
    chk("post_rst_cap", o_cap_rdy, 1);
    expq = {};
    push_const(32'hB);
    capture(mb);
    stream(16, 0, -1, ma);
    idle_tick();
    chk("post_rst_end", o_data_vld, 0);

    // SIZE=1 instance: three matrices back to back
    @(negedge clk);
    s_rdy = 1;
    s_vld = 1;
    s_m[0][0] = 32'h1;
    #1;
    chk("s1_cap0", s_cap, 1);
    chk("s1_vld0", s_dv, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      s_vld = (k < 3);
      s_m[0][0] = 32'(k + 1);
      #1;
      chk("s1_vld", s_dv, 1);
      chk("s1_data", s_d, k);
      chk("s1_last", s_l, 1);
      chk("s1_row", s_r, 0);
      chk("s1_col", s_c, 0);
      chk("s1_cap", s_cap, 1);
    end
    @(negedge clk);
    s_vld = 0;
    #1;
    chk("s1_end_vld", s_dv, 0);
    chk("s1_ovf", s_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_result_streamer.md
Name: sa_result_streamer

Overview:
- Reader for the systolic array result port: captures one SIZE x SIZE result matrix on `o_matrix_vld` from `sa`.
- Drains the matrix as a row-major stream of Y_WIDTH elements over a valid/ready handshake toward a DMA or host link.
- Single-matrix buffer; back-to-back matrices supported with zero bubble cycles.
- Matrices arriving while the buffer is busy are dropped and flagged.

Parameters:
- SIZE, 4, matrix dimension. Legal range 1..16.
- Y_WIDTH, 32, result element width. Identical to `sa` Y_WIDTH.
- IDX_W, (SIZE>1 ? $clog2(SIZE) : 1), derived width of the row/col index. Must not be overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- i_matrix_vld  in  1  result matrix valid; connects to `sa` o_matrix_vld.
- i_matrix  in  Y_WIDTH x [SIZE][SIZE]  result matrix; connects to `sa` o_matrix.
- o_cap_rdy  out  1  a matrix presented this cycle will be captured.
- o_data_vld  out  1  stream element valid.
- o_data  out  Y_WIDTH  stream element.
- o_row  out  IDX_W  row index of o_data.
- o_col  out  IDX_W  column index of o_data.
- o_last  out  1  o_data is element [SIZE-1][SIZE-1].
- i_data_rdy  in  1  downstream accepts the element.
- o_ovf  out  1  sticky: a matrix was dropped.
- i_ovf_clr  in  1  clears o_ovf.

Behaviour:
- Reset values (async, immediate on rst_n low): state IDLE, o_data_vld=0, o_data=0, o_row=0, o_col=0, o_last=0, o_ovf=0. Buffer contents are don't-care.
- Reset mid-stream: the current matrix is abandoned. After reset release the block is IDLE with o_cap_rdy=1.
- FSM has two states, IDLE and SEND.
  - IDLE: o_cap_rdy=1, o_data_vld=0. On i_matrix_vld: latch all SIZE*SIZE elements, set row=col=0, go to SEND.
  - SEND: o_data_vld=1; o_data = buf[row][col]; o_last = (row==SIZE-1 && col==SIZE-1).
- Beat = o_data_vld & i_data_rdy. On a beat:
  - col increments.
  - When col==SIZE-1, col wraps to 0 and row increments.
  - On the last beat, row and col both wrap to 0.
- Stall: with o_data_vld=1 and i_data_rdy=0, o_data, o_row, o_col and o_last hold stable. o_data_vld never drops before its beat.
- Capture-ready logic: o_cap_rdy = (state==IDLE) | (o_data_vld & i_data_rdy & o_last). This is combinational from i_data_rdy.
- Back-to-back capture: i_matrix_vld in the same cycle as the last beat reloads the buffer, resets indices to 0 and stays in SEND. The next cycle shows the new [0][0] with no bubble.
- Last beat without a new matrix: go to IDLE; o_data_vld=0 next cycle.
- Latency: capture at cycle N puts element [0][0] valid at cycle N+1. Minimum drain time is SIZE*SIZE cycles.
- Overflow: i_matrix_vld=1 while o_cap_rdy=0 drops the incoming matrix and sets o_ovf=1 next cycle. The current stream is unaffected.
- o_ovf is cleared by i_ovf_clr. A simultaneous set and clear leaves o_ovf=1 (set wins).
- SIZE=1: every beat is last; o_row=o_col=0 always.
- Elements are passed through unmodified, with no width change or sign handling.

Test Plan:
- Basic drain: SIZE=4, matrix[i][j]=16*i+j, i_data_rdy tied 1 -> 16 beats on consecutive cycles carrying 0x00..0x33 row-major; o_last only on 0x33; o_data_vld low the following cycle.
- Backpressure: i_data_rdy random with 50% duty, same matrix -> identical 16-value sequence; o_data, o_row and o_col stable across every stalled cycle; no element lost or duplicated.
- Back-to-back: matrix A (all 0xA) and matrix B (all 0xB) with B's i_matrix_vld aligned to A's last beat -> 32 contiguous beats, 16x 0xA then 16x 0xB, no idle cycle; o_ovf stays 0.
- Overflow: second matrix presented at beat 5 of the first -> first matrix streamed intact; second matrix never appears; o_ovf=1 one cycle later. i_ovf_clr pulsed alone -> 0. i_ovf_clr pulsed together with a new drop -> stays 1.
- Reset mid-stream: assert rst_n low after beat 7 -> o_data_vld, o_last and o_ovf go to 0 immediately and o_row=o_col=0. After release, a new matrix streams from [0][0].
- SIZE=1 build: three matrices 0x1, 0x2, 0x3 on consecutive cycles with i_data_rdy=1 -> three beats 0x1, 0x2, 0x3, each with o_last=1; no overflow.
